// File: rtl/com_bus_mem_responder.sv
// Common-bus memory responder: grants one cache at a time (round-robin) and returns one word per grant.
// Latency: grant one edge after request, data strobe MEM_LATENCY edges after the address-capture edge.
// Backpressure: requesters hold Req until done; losers wait with Req held, an early Req drop aborts.
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

module com_bus_mem_responder #(
  parameter int N_REQ       = 4,
  parameter int MEM_LATENCY = 4,
  parameter int MEM_AW      = 10
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        Com_Bus_Req_proc,
  output logic [N_REQ-1:0]        Com_Bus_Gnt_proc,
  input  logic [`ADDRESSSIZE-1:0] Address_Com,
  output wire  [`ADDRESSSIZE-1:0] Data_Bus_Com,
  output logic                    Data_in_Bus,
  input  logic                    mem_wr_en,
  input  logic [MEM_AW-1:0]       mem_wr_addr,
  input  logic [`ADDRESSSIZE-1:0] mem_wr_data
);

  localparam int DW = `ADDRESSSIZE;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, RESP, RELEASE} state_t;

  state_t            state_q, state_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [PW-1:0]     rr_ptr, rr_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic [MEM_AW-1:0] idx_q, idx_nxt;
  logic [DW-1:0]     dat_q;
  logic              dib_nxt;
  logic              load_dat;
  logic              gnt_req_hi;
  logic [N_REQ-1:0]  win_oh;
  logic [PW-1:0]     win_ptr;
  logic [PW-1:0]     cand;
  logic              found;
  logic              unused_addr_bits;

  logic [DW-1:0] mem [2**MEM_AW];

  // Byte offset and bits above the array range never take part in the word index.
  assign unused_addr_bits = ^{Address_Com[1:0], Address_Com[DW-1:MEM_AW+2]};

  // The granted cache still wants the bus.
  assign gnt_req_hi = |(Com_Bus_Req_proc & Com_Bus_Gnt_proc);

  // Read data is only put on the shared bus during the strobe cycle.
  assign Data_Bus_Com = Data_in_Bus ? dat_q : {DW{1'bz}};

  // Round-robin pick: first requester at or after rr_ptr.
  always_comb begin
    win_oh  = '0;
    win_ptr = rr_ptr;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && Com_Bus_Req_proc[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_ptr      = PW'((int'(cand) + 1) % N_REQ);
      end
    end
  end

  // Transaction FSM: next state and next values of all registered outputs.
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = Com_Bus_Gnt_proc;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    dib_nxt   = 1'b0;
    load_dat  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_nxt = '0;
        if (found) begin
          gnt_nxt   = win_oh;
          rr_nxt    = win_ptr;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (!gnt_req_hi) begin
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = Address_Com[MEM_AW+1:2];
          cnt_nxt   = 4'(MEM_LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // An abort wins over a read that would complete on the same edge.
        if (!gnt_req_hi) begin
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt_q == 4'd0) begin
          load_dat  = 1'b1;
          dib_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!gnt_req_hi) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; the array read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q          <= IDLE;
      Com_Bus_Gnt_proc <= '0;
      rr_ptr           <= '0;
      cnt_q            <= '0;
      idx_q            <= '0;
      dat_q            <= '0;
      Data_in_Bus      <= 1'b0;
    end else begin
      state_q          <= state_nxt;
      Com_Bus_Gnt_proc <= gnt_nxt;
      rr_ptr           <= rr_nxt;
      cnt_q            <= cnt_nxt;
      idx_q            <= idx_nxt;
      Data_in_Bus      <= dib_nxt;
      if (load_dat) begin
        dat_q <= mem[idx_q];
      end
    end
  end

  // Preload port: writes in any state, held off during reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (RST && mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

endmodule

// File: tb/tb_com_bus_mem_responder.sv
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

module tb_com_bus_mem_responder;

  localparam int N  = 4;
  localparam int L  = 4;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          RST;
  logic [N-1:0]  Com_Bus_Req_proc;
  logic [N-1:0]  Com_Bus_Gnt_proc;
  logic [31:0]   Address_Com;
  wire  [31:0]   Data_Bus_Com;
  logic          Data_in_Bus;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;

  int          n_chk;
  int          n_fail;
  int          cyc;
  int          ptr_m;
  bit          mon_on;
  exp_t        exp_q[$];
  exp_t        e_m;
  logic [31:0] model_mem [2**AW];

  com_bus_mem_responder #(.N_REQ(N), .MEM_LATENCY(L), .MEM_AW(AW)) dut (
    .clk              (clk),
    .RST              (RST),
    .Com_Bus_Req_proc (Com_Bus_Req_proc),
    .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
    .Address_Com      (Address_Com),
    .Data_Bus_Com     (Data_Bus_Com),
    .Data_in_Bus      (Data_in_Bus),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation in data and timing.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (Data_in_Bus === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data %h with no transaction outstanding (edge %0d)",
                   Data_Bus_Com, cyc);
        end else begin
          e_m = exp_q.pop_front();
          chk("strobe_data", Data_Bus_Com, e_m.dat);
          chk("strobe_edge", cyc, e_m.cyc);
        end
      end else begin
        chk("strobe_low", {31'b0, Data_in_Bus}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input int at);
    exp_t e;
    e.dat = d;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // One negedge later the grant must be exactly cache w.
  task automatic wait_grant(input int w);
    @(negedge clk);
    chk("grant", {28'b0, Com_Bus_Gnt_proc}, {28'b0, onehot(w)});
    ptr_m = (w + 1) % N;
  endtask

  // Called on the negedge where the grant to w is visible; runs the rest of the transaction.
  task automatic serve(input int w, input logic [31:0] addr, input bit wr5);
    bit seen;
    Address_Com = addr;
    push_exp(model_mem[addr[AW+1:2]], cyc + 1 + L);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      Address_Com = $urandom();
      mem_wr_en   = wr5 && (k == L);
      mem_wr_addr = 10'd5;
      mem_wr_data = 32'h1234_5678;
      if (Data_in_Bus) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL strobe_timeout: cache %0d got no strobe within 40 cycles", w);
    end
    @(negedge clk);
    Com_Bus_Req_proc[w] = 1'b0;
    @(negedge clk);
    chk("grant_release", {28'b0, Com_Bus_Gnt_proc}, 32'd0);
  endtask

  int           st  [N];
  int           cnt [N];
  logic [31:0]  ca  [N];
  logic [N-1:0] g, gprev, rq, exp_g;
  bit           exp_g_vld;
  bit           allow_new;
  int           w;

  // One random-phase cycle: check last prediction, step each cache, predict next grant.
  task automatic rand_step();
    @(negedge clk);
    g = Com_Bus_Gnt_proc;
    if (exp_g_vld) chk("rand_grant", {28'b0, g}, {28'b0, exp_g});
    Address_Com = $urandom();
    rq = Com_Bus_Req_proc;
    for (int i = 0; i < N; i++) begin
      case (st[i])
        0: begin
          if (allow_new) begin
            if (cnt[i] == 0) begin
              st[i] = 1;
              ca[i] = $urandom();
              rq[i] = 1'b1;
            end else begin
              cnt[i]--;
            end
          end
        end
        1: begin
          if (g[i] && !gprev[i]) begin
            Address_Com = ca[i];
            if ($urandom_range(0, 3) == 0) begin
              st[i]  = 3;
              cnt[i] = $urandom_range(0, L);
              if (cnt[i] == 0) begin
                rq[i]  = 1'b0;
                st[i]  = 0;
                cnt[i] = $urandom_range(0, 6);
              end
            end else begin
              st[i] = 2;
              push_exp(model_mem[ca[i][AW+1:2]], cyc + 1 + L);
            end
          end
        end
        2: begin
          if (Data_in_Bus) begin
            st[i]  = 4;
            cnt[i] = $urandom_range(1, 3);
          end
        end
        default: begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            rq[i]  = 1'b0;
            st[i]  = 0;
            cnt[i] = $urandom_range(0, 6);
          end
        end
      endcase
    end
    if (g == '0) begin
      exp_g = '0;
      if (rq != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && rq[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        end
        exp_g = onehot(w);
        ptr_m = (w + 1) % N;
      end
    end else begin
      exp_g = ((rq & g) != '0) ? g : '0;
    end
    exp_g_vld = 1'b1;
    gprev = g;
    Com_Bus_Req_proc = rq;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    mon_on = 1'b0;
    RST = 1'b0;
    Com_Bus_Req_proc = '0;
    Address_Com = '0;
    mem_wr_en = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    ptr_m = 0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", {28'b0, Com_Bus_Gnt_proc}, 32'd0);
    chk("reset_strobe", {31'b0, Data_in_Bus}, 32'd0);
    mon_on = 1'b1;
    RST = 1'b1;

    // Preload the whole array, word 5 last.
    for (int i = 0; i < 2**AW; i++) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = AW'(i);
      mem_wr_data = (i == 5) ? 32'hDEAD_BEEF : $urandom();
      model_mem[i] = mem_wr_data;
      @(negedge clk);
    end
    mem_wr_en = 1'b0;

    // All four request together: served 0,1,2,3 with one idle cycle in between.
    Com_Bus_Req_proc = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_grant(i);
      serve(i, 32'h40 + 32'(4 * i), 1'b0);
    end

    // Single read of word 5 via byte address 0x14.
    Com_Bus_Req_proc = 4'b0100;
    wait_grant(2);
    serve(2, 32'h14, 1'b0);

    // Cache 1 aborts in WAIT; pending cache 3 is served next.
    Com_Bus_Req_proc = 4'b0010;
    wait_grant(1);
    Address_Com = 32'h14;
    Com_Bus_Req_proc[3] = 1'b1;
    repeat (2) @(negedge clk);
    Com_Bus_Req_proc[1] = 1'b0;
    @(negedge clk);
    chk("abort_gnt", {28'b0, Com_Bus_Gnt_proc}, 32'd0);
    wait_grant(3);
    serve(3, 32'h80, 1'b0);

    // Reset during WAIT, with a preload attempt that must be ignored.
    Com_Bus_Req_proc = 4'b0001;
    wait_grant(0);
    Address_Com = 32'h14;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    mem_wr_en = 1'b1;
    mem_wr_addr = 10'd5;
    mem_wr_data = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rst_mid_gnt", {28'b0, Com_Bus_Gnt_proc}, 32'd0);
    chk("rst_mid_strobe", {31'b0, Data_in_Bus}, 32'd0);
    RST = 1'b1;
    mem_wr_en = 1'b0;
    ptr_m = 0;
    wait_grant(0);
    serve(0, 32'h14, 1'b0);

    // Preload on the RESP-entry edge: strobe has the old word, the next read the new one.
    Com_Bus_Req_proc = 4'b0010;
    wait_grant(1);
    serve(1, 32'h14, 1'b1);
    model_mem[5] = 32'h1234_5678;
    Com_Bus_Req_proc = 4'b0100;
    wait_grant(2);
    serve(2, 32'h14, 1'b0);

    // Upper address bits ignored.
    Com_Bus_Req_proc = 4'b1000;
    wait_grant(3);
    serve(3, 32'hFFFF_F014, 1'b0);

    // Randomized traffic with random aborts, then drain.
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      cnt[i] = $urandom_range(0, 4);
    end
    gprev = '0;
    exp_g_vld = 1'b0;
    allow_new = 1'b1;
    repeat (3000) rand_step();
    allow_new = 1'b0;
    repeat (300) rand_step();

    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_gnt", {28'b0, Com_Bus_Gnt_proc}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
